// File: rtl/tri_raster_sequencer_if.sv
// -----------------------------------------------------------------------------
// tri_raster_sequencer_if
// Groups the frame-control, FIFO-status and pipe-handshake signals of the
// triangle raster sequencer into one bundle.
//
//   frame_start / frame_abort / tri_count : frame control from the host
//   vertex_size / tri_fifo_level          : triangle FIFO occupancy
//   frag_fifo_threshold                   : fragment FIFO throttle
//   pipe_ready / pipe_done / pipe_start   : handshake with the raster pipe
//   frame_busy / frame_done / timeout_err : frame status
//   tris_issued / tris_retired            : per-frame triangle counters
//   busy_cycles / stall_cycles            : perf counters (TRI_SEQ_PERF_EN only)
//
// Modports: master = host/pipe side, slave = sequencer.
// Optional feature macro: TRI_SEQ_PERF_EN.
// -----------------------------------------------------------------------------
interface tri_raster_sequencer_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int LEVEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
);
    logic                   frame_start;
    logic                   frame_abort;
    logic [CNT_WIDTH-1:0]   tri_count;
    logic [ADDR_WIDTH-1:0]  vertex_size;
    logic [LEVEL_WIDTH-1:0] tri_fifo_level;
    logic                   frag_fifo_threshold;
    logic                   pipe_ready;
    logic                   pipe_done;
    logic                   pipe_start;
    logic                   frame_busy;
    logic                   frame_done;
    logic                   timeout_err;
    logic [CNT_WIDTH-1:0]   tris_issued;
    logic [CNT_WIDTH-1:0]   tris_retired;
`ifdef TRI_SEQ_PERF_EN
    logic [31:0]            busy_cycles;
    logic [31:0]            stall_cycles;
`endif

    modport master (
        output frame_start, frame_abort, tri_count, vertex_size,
               tri_fifo_level, frag_fifo_threshold, pipe_ready, pipe_done,
        input  pipe_start, frame_busy, frame_done, timeout_err,
               tris_issued, tris_retired
`ifdef TRI_SEQ_PERF_EN
        , input busy_cycles, stall_cycles
`endif
    );

    modport slave (
        input  frame_start, frame_abort, tri_count, vertex_size,
               tri_fifo_level, frag_fifo_threshold, pipe_ready, pipe_done,
        output pipe_start, frame_busy, frame_done, timeout_err,
               tris_issued, tris_retired
`ifdef TRI_SEQ_PERF_EN
        , output busy_cycles, stall_cycles
`endif
    );
endinterface

// File: rtl/tri_raster_sequencer.sv
// -----------------------------------------------------------------------------
// tri_raster_sequencer
// Frame-level sequencer for the triangle rasteriser pipe. A frame_start loads
// the triangle count; one pipe_start pulse is then issued per triangle, each
// only when the triangle FIFO holds a whole triangle (3*vertex_size words),
// the fragment FIFO is not throttling and the pipe is ready. Each triangle in
// flight is guarded by a watchdog; expiry parks the FSM in ERROR with a sticky
// timeout_err until frame_abort (or reset) and a new frame_start.
//
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : tri_raster_sequencer_if.slave (see interface header)
//
// Optional feature macro: TRI_SEQ_PERF_EN adds busy_cycles / stall_cycles.
// -----------------------------------------------------------------------------
module tri_raster_sequencer #(
    parameter int ADDR_WIDTH     = 4,
    parameter int LEVEL_WIDTH    = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                   clk,
    input logic                   resetn,
    tri_raster_sequencer_if.slave bus
);
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_TRI = 2'd1,
        ST_RUN      = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t                 state_r, state_n;
    logic [CNT_WIDTH-1:0]   count_r, count_n;
    logic [CNT_WIDTH-1:0]   issued_r, issued_n;
    logic [CNT_WIDTH-1:0]   retired_r, retired_n;
    logic [WD_WIDTH-1:0]    wd_r, wd_n;
    logic                   pipe_start_r, pipe_start_n;
    logic                   frame_done_r, frame_done_n;
    logic                   frame_busy_r, frame_busy_n;
    logic                   timeout_err_r, timeout_err_n;

    logic [ADDR_WIDTH+1:0]  need_wide_s;
    logic                   level_ok_s;
    logic                   issue_ok_s;
    logic                   all_issued_s;

    // Words needed for one triangle and the resulting issue qualifiers.
    always_comb begin
        need_wide_s  = {2'b00, bus.vertex_size} + {1'b0, bus.vertex_size, 1'b0};
        level_ok_s   = (bus.tri_fifo_level >= LEVEL_WIDTH'(need_wide_s));
        issue_ok_s   = bus.pipe_ready & level_ok_s & ~bus.frag_fifo_threshold;
        all_issued_s = (issued_r == count_r);
    end

    // Next-state and next-output logic; frame_abort overrides every state.
    always_comb begin
        state_n       = state_r;
        count_n       = count_r;
        issued_n      = issued_r;
        retired_n     = retired_r;
        wd_n          = wd_r;
        pipe_start_n  = 1'b0;
        frame_done_n  = 1'b0;
        timeout_err_n = timeout_err_r;

        if (bus.frame_abort) begin
            // Counters are left untouched so they can be inspected afterwards.
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        count_n       = bus.tri_count;
                        issued_n      = {CNT_WIDTH{1'b0}};
                        retired_n     = {CNT_WIDTH{1'b0}};
                        timeout_err_n = 1'b0;
                        if (bus.tri_count == {CNT_WIDTH{1'b0}}) begin
                            frame_done_n = 1'b1;
                        end else begin
                            state_n = ST_WAIT_TRI;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_WAIT_TRI: begin
                    if (all_issued_s) begin
                        state_n      = ST_IDLE;
                        frame_done_n = 1'b1;
                    end else if (issue_ok_s) begin
                        pipe_start_n = 1'b1;
                        issued_n     = issued_r + CNT_WIDTH'(1);
                        wd_n         = {WD_WIDTH{1'b0}};
                        state_n      = ST_RUN;
                    end else begin
                        state_n = ST_WAIT_TRI;
                    end
                end
                ST_RUN: begin
                    // A done arriving on the expiry cycle still retires the triangle.
                    if (bus.pipe_done) begin
                        retired_n = retired_r + CNT_WIDTH'(1);
                        state_n   = ST_WAIT_TRI;
                    end else if (wd_r == WD_LAST) begin
                        timeout_err_n = 1'b1;
                        state_n       = ST_ERROR;
                    end else begin
                        wd_n = wd_r + WD_WIDTH'(1);
                    end
                end
                ST_ERROR: begin
                    state_n = ST_ERROR;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        frame_busy_n = (state_n == ST_WAIT_TRI) || (state_n == ST_RUN);
    end

    // State, counters and all status outputs are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            count_r       <= {CNT_WIDTH{1'b0}};
            issued_r      <= {CNT_WIDTH{1'b0}};
            retired_r     <= {CNT_WIDTH{1'b0}};
            wd_r          <= {WD_WIDTH{1'b0}};
            pipe_start_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_busy_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            count_r       <= count_n;
            issued_r      <= issued_n;
            retired_r     <= retired_n;
            wd_r          <= wd_n;
            pipe_start_r  <= pipe_start_n;
            frame_done_r  <= frame_done_n;
            frame_busy_r  <= frame_busy_n;
            timeout_err_r <= timeout_err_n;
        end
    end

    assign bus.pipe_start   = pipe_start_r;
    assign bus.frame_done   = frame_done_r;
    assign bus.frame_busy   = frame_busy_r;
    assign bus.timeout_err  = timeout_err_r;
    assign bus.tris_issued  = issued_r;
    assign bus.tris_retired = retired_r;

`ifdef TRI_SEQ_PERF_EN
    logic [31:0] busy_cycles_r;
    logic [31:0] stall_cycles_r;
    logic        accept_start_s;
    logic        in_frame_s;
    logic        stalled_s;

    // Perf qualifiers: stall means a triangle is pending but the FIFOs block it.
    always_comb begin
        accept_start_s = (state_r == ST_IDLE) & bus.frame_start & ~bus.frame_abort;
        in_frame_s     = (state_r == ST_WAIT_TRI) || (state_r == ST_RUN);
        stalled_s      = (state_r == ST_WAIT_TRI) & ~all_issued_s &
                         (~level_ok_s | bus.frag_fifo_threshold);
    end

    // Saturating perf counters, cleared when a new frame is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_cycles_r  <= 32'd0;
            stall_cycles_r <= 32'd0;
        end else if (accept_start_s) begin
            busy_cycles_r  <= 32'd0;
            stall_cycles_r <= 32'd0;
        end else begin
            if (in_frame_s && (busy_cycles_r != 32'hFFFF_FFFF)) begin
                busy_cycles_r <= busy_cycles_r + 32'd1;
            end else begin
                busy_cycles_r <= busy_cycles_r;
            end
            if (stalled_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    assign bus.busy_cycles  = busy_cycles_r;
    assign bus.stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_tri_raster_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tri_raster_sequencer
// Self-checking bench: a cycle-level reference model of the frame sequencer
// is stepped on every clock and compared against the DUT, plus a table of
// hand-derived vectors and directed corner-case sequences, then random frames.
// -----------------------------------------------------------------------------
module tb_tri_raster_sequencer;
    localparam int AW = 4;
    localparam int LW = 8;
    localparam int CW = 16;
    localparam int TO = 4096;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_ERR  = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tri_raster_sequencer_if #(.ADDR_WIDTH(AW), .LEVEL_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

    tri_raster_sequencer #(
        .ADDR_WIDTH(AW), .LEVEL_WIDTH(LW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame phase plus plain integer bookkeeping.
    int     m_phase, m_count, m_issued, m_retired, m_age;
    bit     m_start, m_fdone, m_terr;
    longint m_busy, m_stall;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_count = 0; m_issued = 0; m_retired = 0; m_age = 0;
        m_start = 0; m_fdone = 0; m_terr = 0; m_busy = 0; m_stall = 0;
    endtask

    // One clock of the model from the inputs present at the edge.
    task automatic model_step();
        int need;
        bit fifo_ok;
        int old;
        need    = 3 * int'(bus.vertex_size);
        fifo_ok = (int'(bus.tri_fifo_level) >= need) && !bus.frag_fifo_threshold;
        old     = m_phase;
        if ((old == P_WAIT || old == P_RUN) && m_busy < 64'hFFFF_FFFF) m_busy++;
        if (old == P_WAIT && m_issued != m_count && !fifo_ok && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_start = 0;
        m_fdone = 0;
        if (bus.frame_abort) begin
            m_phase = P_IDLE;
        end else begin
            case (old)
                P_IDLE: if (bus.frame_start) begin
                    m_count = int'(bus.tri_count); m_issued = 0; m_retired = 0; m_terr = 0;
                    m_busy = 0; m_stall = 0;
                    if (m_count == 0) m_fdone = 1; else m_phase = P_WAIT;
                end
                P_WAIT: if (m_issued == m_count) begin
                    m_phase = P_IDLE; m_fdone = 1;
                end else if (fifo_ok && bus.pipe_ready) begin
                    m_start = 1; m_issued++; m_age = 0; m_phase = P_RUN;
                end
                P_RUN: if (bus.pipe_done) begin
                    m_retired++; m_phase = P_WAIT;
                end else if (m_age == TO - 1) begin
                    m_phase = P_ERR; m_terr = 1;
                end else begin
                    m_age++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_model();
        check("mdl_pipe_start",   bus.pipe_start,   m_start);
        check("mdl_frame_busy",   bus.frame_busy,   (m_phase == P_WAIT || m_phase == P_RUN));
        check("mdl_frame_done",   bus.frame_done,   m_fdone);
        check("mdl_timeout_err",  bus.timeout_err,  m_terr);
        check("mdl_tris_issued",  bus.tris_issued,  m_issued);
        check("mdl_tris_retired", bus.tris_retired, m_retired);
`ifdef TRI_SEQ_PERF_EN
        check("mdl_busy_cycles",  bus.busy_cycles,  m_busy);
        check("mdl_stall_cycles", bus.stall_cycles, m_stall);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic set_in(input bit fs, input bit fa, input int cnt, input int vs,
                          input int lvl, input bit thr, input bit rdy, input bit done);
        bus.frame_start = fs; bus.frame_abort = fa; bus.tri_count = CW'(cnt);
        bus.vertex_size = AW'(vs); bus.tri_fifo_level = LW'(lvl);
        bus.frag_fifo_threshold = thr; bus.pipe_ready = rdy; bus.pipe_done = done;
    endtask

    typedef struct {
        bit fs, fa; int cnt, vs, lvl; bit thr, rdy, done;
        bit e_start, e_busy, e_fdone, e_terr; int e_iss, e_ret;
    } vec_t;

    function automatic vec_t mkv(bit fs, bit fa, int cnt, int lvl, bit thr, bit rdy, bit done,
                                 bit es, bit eb, bit ed, int ei, int er);
        vec_t v;
        v.fs = fs; v.fa = fa; v.cnt = cnt; v.vs = 1; v.lvl = lvl; v.thr = thr; v.rdy = rdy;
        v.done = done; v.e_start = es; v.e_busy = eb; v.e_fdone = ed; v.e_terr = 1'b0;
        v.e_iss = ei; v.e_ret = er;
        return v;
    endfunction

    vec_t vt[13];

    initial begin
        int starts, fdones, cd, k;
        bit seen;

        // Table: vertex_size=1, so one triangle needs 3 words.
        //          fs fa cnt lvl thr rdy done | start busy fdone iss ret
        vt[0]  = mkv(1, 0, 0, 3, 0, 1, 0,       0, 0, 1, 0, 0);  // empty frame
        vt[1]  = mkv(0, 0, 0, 3, 0, 1, 0,       0, 0, 0, 0, 0);
        vt[2]  = mkv(1, 0, 1, 3, 0, 1, 0,       0, 1, 0, 0, 0);  // one triangle
        vt[3]  = mkv(0, 0, 0, 2, 0, 1, 0,       0, 1, 0, 0, 0);  // level short
        vt[4]  = mkv(0, 0, 0, 3, 1, 1, 0,       0, 1, 0, 0, 0);  // throttled
        vt[5]  = mkv(0, 0, 0, 3, 0, 0, 0,       0, 1, 0, 0, 0);  // pipe not ready
        vt[6]  = mkv(0, 0, 0, 3, 0, 1, 0,       1, 1, 0, 1, 0);  // issue
        vt[7]  = mkv(0, 0, 0, 3, 0, 1, 0,       0, 1, 0, 1, 0);
        vt[8]  = mkv(0, 0, 0, 3, 0, 1, 1,       0, 1, 0, 1, 1);  // retire
        vt[9]  = mkv(0, 0, 0, 3, 0, 1, 0,       0, 0, 1, 1, 1);  // frame done
        vt[10] = mkv(0, 0, 0, 3, 0, 1, 1,       0, 0, 0, 1, 1);  // stray done
        vt[11] = mkv(1, 0, 2, 3, 0, 1, 0,       0, 1, 0, 0, 0);
        vt[12] = mkv(0, 1, 0, 3, 0, 1, 0,       0, 0, 0, 0, 0);  // abort in WAIT_TRI

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_model();                     // reset state
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            set_in(vt[i].fs, vt[i].fa, vt[i].cnt, vt[i].vs, vt[i].lvl, vt[i].thr, vt[i].rdy, vt[i].done);
            tick();
            check($sformatf("vec%0d_start", i),   bus.pipe_start,   vt[i].e_start);
            check($sformatf("vec%0d_busy", i),    bus.frame_busy,   vt[i].e_busy);
            check($sformatf("vec%0d_fdone", i),   bus.frame_done,   vt[i].e_fdone);
            check($sformatf("vec%0d_terr", i),    bus.timeout_err,  vt[i].e_terr);
            check($sformatf("vec%0d_issued", i),  bus.tris_issued,  vt[i].e_iss);
            check($sformatf("vec%0d_retired", i), bus.tris_retired, vt[i].e_ret);
        end

        // Three triangles, done 5 cycles after each start.
        set_in(1, 0, 3, 3, 9, 0, 1, 0);
        tick();
        bus.frame_start = 1'b0;
        starts = 0; fdones = 0; cd = 0;
        for (int c = 0; c < 200 && fdones == 0; c++) begin
            bus.pipe_done = (cd == 1);
            tick();
            if (cd > 0) cd--;
            if (bus.pipe_start) begin starts++; cd = 5; end
            if (bus.frame_done) fdones++;
        end
        bus.pipe_done = 1'b0;
        tick();
        if (bus.frame_done) fdones++;
        check("run3_starts", starts, 3);
        check("run3_frame_done", fdones, 1);
        check("run3_issued", bus.tris_issued, 3);
        check("run3_retired", bus.tris_retired, 3);
`ifdef TRI_SEQ_PERF_EN
        check("run3_busy_cycles", bus.busy_cycles, 19);
`endif

        // Level one word short until cycle 20, then throttle blocks the second.
        set_in(1, 0, 2, 3, 8, 0, 1, 0);
        tick();
        bus.frame_start = 1'b0;
        seen = 0;
        for (int c = 1; c < 20; c++) begin
            tick();
            if (bus.pipe_start) seen = 1;
        end
        check("lvl8_no_start", seen, 0);
        bus.tri_fifo_level = 8'd9;
        tick();
        check("lvl9_start", bus.pipe_start, 1);
        bus.frag_fifo_threshold = 1'b1;
        tick();
        bus.pipe_done = 1'b1;
        tick();
        bus.pipe_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.pipe_start) seen = 1;
        end
        check("thr_no_start", seen, 0);
        bus.frag_fifo_threshold = 1'b0;
        tick();
        check("thr_release_start", bus.pipe_start, 1);
        bus.pipe_done = 1'b1;
        tick();
        bus.pipe_done = 1'b0;
        tick();
        check("thr_frame_done", bus.frame_done, 1);

        // Watchdog: no done ever arrives.
        set_in(1, 0, 1, 1, 3, 0, 1, 0);
        tick();
        bus.frame_start = 1'b0;
        tick();
        check("wd_start", bus.pipe_start, 1);
        k = 0;
        for (int c = 0; c < TO + 10 && !bus.timeout_err; c++) begin
            tick();
            k++;
        end
        check("wd_latency", k, TO);
        check("wd_busy_low", bus.frame_busy, 0);
        bus.frame_start = 1'b1;              // ignored in ERROR
        tick();
        check("wd_err_sticky", bus.timeout_err, 1);
        set_in(0, 1, 0, 1, 3, 0, 1, 0);
        tick();
        set_in(1, 0, 0, 1, 3, 0, 1, 0);
        tick();
        check("wd_err_cleared", bus.timeout_err, 0);
        check("wd_new_frame_done", bus.frame_done, 1);

        // Done on the expiry cycle wins over the timeout.
        set_in(1, 0, 1, 1, 3, 0, 1, 0);
        tick();
        bus.frame_start = 1'b0;
        tick();
        repeat (TO - 1) tick();
        bus.pipe_done = 1'b1;
        tick();
        bus.pipe_done = 1'b0;
        check("wd_done_wins_err", bus.timeout_err, 0);
        check("wd_done_wins_ret", bus.tris_retired, 1);
        tick();

        // Abort in RUN with two triangles issued.
        set_in(1, 0, 3, 1, 3, 0, 1, 0);
        tick();
        bus.frame_start = 1'b0;
        tick();
        bus.pipe_done = 1'b1;
        tick();
        bus.pipe_done = 1'b0;
        tick();
        check("abort_pre_issued", bus.tris_issued, 2);
        bus.frame_abort = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        check("abort_busy", bus.frame_busy, 0);
        check("abort_no_fdone", bus.frame_done, 0);
        check("abort_issued", bus.tris_issued, 2);
        bus.pipe_done = 1'b1;
        tick();
        bus.pipe_done = 1'b0;
        check("abort_stray_done", bus.tris_retired, 1);

        // Reset while pipe_start is high.
        set_in(1, 0, 2, 1, 3, 0, 1, 0);
        tick();
        bus.frame_start = 1'b0;
        tick();
        check("rst_pre_start", bus.pipe_start, 1);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare_model();
        check("rst_async_start", bus.pipe_start, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Random frames.
        for (int c = 0; c < 4000; c++) begin
            set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
